// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state IEEE 1149.1 TAP FSM with instruction register,
// EXTEST/INTEST/SAMPLE/BYPASS decode, a 1-bit bypass register and the
// boundary-scan chain control strobes.
//
// Ports:
//   clk, rst          - TCK-role clock, synchronous active-high reset
//   tms, tdi          - test mode select / serial data in (sampled on rising clk)
//   bsr_tdo           - serial out of the external boundary-scan chain
//   tdo, tdo_en       - serial data out and its valid (Shift-IR / Shift-DR)
//   shift_dr, capture_dr, update_dr - boundary register control strobes
//   mode, sel         - BSR cell mode / DR select (1 = boundary, 0 = bypass)
//   bp_shift          - bypass register shift enable
//   ir, tap_state     - current instruction and TAP state code
module jtag_tap_ctrl #(
    parameter int unsigned     IR_W        = 3,
    parameter logic [IR_W-1:0] BYPASS_CODE = '1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tms,
    input  logic            tdi,
    input  logic            bsr_tdo,
    output logic            tdo,
    output logic            tdo_en,
    output logic            shift_dr,
    output logic            capture_dr,
    output logic            update_dr,
    output logic            mode,
    output logic            sel,
    output logic            bp_shift,
    output logic [IR_W-1:0] ir,
    output logic [3:0]      tap_state
);

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PA_DR  = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PA_IR  = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_t;

    localparam logic [IR_W-1:0] C_EXTEST  = IR_W'(0);
    localparam logic [IR_W-1:0] C_INTEST  = IR_W'(1);
    localparam logic [IR_W-1:0] C_SAMPLE  = IR_W'(2);
    localparam logic [IR_W-1:0] C_IR_CAPT = IR_W'(2'b01);

    tap_state_t      r_state;
    tap_state_t      w_next;
    logic [IR_W-1:0] r_ir_sr;
    logic [IR_W-1:0] r_ir;
    logic            r_bp;

    logic w_mode, w_sel, w_shift_dr, w_capture_dr, w_update_dr, w_bp_shift;
    logic w_tdo, w_tdo_en;

    // TAP state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= TLR;
        else     r_state <= w_next;
    end

    // Next-state TMS graph and Moore output decode
    always_comb begin
        w_next       = r_state;
        w_mode       = 1'b0;
        w_sel        = 1'b0;
        w_shift_dr   = 1'b0;
        w_capture_dr = 1'b0;
        w_update_dr  = 1'b0;
        w_bp_shift   = 1'b0;
        w_tdo        = 1'b0;
        w_tdo_en     = 1'b0;

        case (r_state)
            TLR:     w_next = tms ? TLR    : RTI;
            RTI:     w_next = tms ? SEL_DR : RTI;
            SEL_DR:  w_next = tms ? SEL_IR : CAP_DR;
            CAP_DR:  w_next = tms ? EX1_DR : SH_DR;
            SH_DR:   w_next = tms ? EX1_DR : SH_DR;
            EX1_DR:  w_next = tms ? UPD_DR : PA_DR;
            PA_DR:   w_next = tms ? EX2_DR : PA_DR;
            EX2_DR:  w_next = tms ? UPD_DR : SH_DR;
            UPD_DR:  w_next = tms ? SEL_DR : RTI;
            SEL_IR:  w_next = tms ? TLR    : CAP_IR;
            CAP_IR:  w_next = tms ? EX1_IR : SH_IR;
            SH_IR:   w_next = tms ? EX1_IR : SH_IR;
            EX1_IR:  w_next = tms ? UPD_IR : PA_IR;
            PA_IR:   w_next = tms ? EX2_IR : PA_IR;
            EX2_IR:  w_next = tms ? UPD_IR : SH_IR;
            UPD_IR:  w_next = tms ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase

        // Instruction decode depends only on the updated IR
        w_mode = (r_ir == C_EXTEST) || (r_ir == C_INTEST);
        w_sel  = w_mode || (r_ir == C_SAMPLE);

        w_shift_dr   = (r_state == SH_DR)  &&  w_sel;
        w_bp_shift   = (r_state == SH_DR)  && !w_sel;
        w_capture_dr = (r_state == CAP_DR) &&  w_sel;
        w_update_dr  = (r_state == UPD_DR) &&  w_sel;
        w_tdo_en     = (r_state == SH_DR)  || (r_state == SH_IR);

        if (r_state == SH_IR)     w_tdo = r_ir_sr[0];
        else if (w_shift_dr)      w_tdo = bsr_tdo;
        else if (w_bp_shift)      w_tdo = r_bp;
    end

    // IR shift register, updated instruction and bypass bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir_sr <= '0;
            r_ir    <= BYPASS_CODE;
            r_bp    <= 1'b0;
        end else begin
            case (r_state)
                TLR:     r_ir    <= BYPASS_CODE;
                CAP_IR:  r_ir_sr <= C_IR_CAPT;
                SH_IR:   r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
                UPD_IR:  r_ir    <= r_ir_sr;
                CAP_DR:  r_bp    <= 1'b0;
                SH_DR:   if (!w_sel) r_bp <= tdi;
                default: ;
            endcase
        end
    end

    assign tdo        = w_tdo;
    assign tdo_en     = w_tdo_en;
    assign shift_dr   = w_shift_dr;
    assign capture_dr = w_capture_dr;
    assign update_dr  = w_update_dr;
    assign mode       = w_mode;
    assign sel        = w_sel;
    assign bp_shift   = w_bp_shift;
    assign ir         = r_ir;
    assign tap_state  = r_state;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Scoreboard bench for jtag_tap_ctrl: directed TMS/TDI vectors push expected
// state/IR/output flags; a negedge monitor pops and compares.
module tb_jtag_tap_ctrl;

    localparam logic [3:0] S_TLR = 4'd0,  S_RTI = 4'd1,  S_SDR = 4'd2,  S_CDR = 4'd3;
    localparam logic [3:0] S_SHD = 4'd4,  S_E1D = 4'd5,  S_PAD = 4'd6,  S_E2D = 4'd7;
    localparam logic [3:0] S_UDR = 4'd8,  S_SIR = 4'd9,  S_CIR = 4'd10, S_SHI = 4'd11;
    localparam logic [3:0] S_E1I = 4'd12, S_UIR = 4'd15;

    // flags = {mode, sel, shift_dr, capture_dr, update_dr, bp_shift, tdo_en, tdo}
    localparam logic [7:0] F_TDO = 8'b0000_0001, F_EN  = 8'b0000_0010;
    localparam logic [7:0] F_BP  = 8'b0000_0100, F_UPD = 8'b0000_1000;
    localparam logic [7:0] F_CAP = 8'b0001_0000, F_SH  = 8'b0010_0000;
    localparam logic [7:0] F_SEL = 8'b0100_0000, F_MOD = 8'b1000_0000;
    localparam logic [7:0] F_0   = 8'b0000_0000;

    logic clk = 1'b0;
    logic rst, tms, tdi, bsr_tdo;
    logic tdo, tdo_en, shift_dr, capture_dr, update_dr, mode, sel, bp_shift;
    logic [2:0] ir;
    logic [3:0] tap_state;

    typedef struct {
        int         idx;
        logic [3:0] st;
        logic [2:0] irv;
        logic [7:0] f;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_steps  = 0;

    always #5 clk = ~clk;

    jtag_tap_ctrl #(.IR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tms        (tms),
        .tdi        (tdi),
        .bsr_tdo    (bsr_tdo),
        .tdo        (tdo),
        .tdo_en     (tdo_en),
        .shift_dr   (shift_dr),
        .capture_dr (capture_dr),
        .update_dr  (update_dr),
        .mode       (mode),
        .sel        (sel),
        .bp_shift   (bp_shift),
        .ir         (ir),
        .tap_state  (tap_state)
    );

    task automatic check(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s step %0d: got %b expected %b", nm, idx, got, exp);
    endtask

    // Monitor: compare the DUT against the oldest expectation, away from the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("tap_state", e.idx, {4'b0, tap_state}, {4'b0, e.st});
            check("ir",        e.idx, {5'b0, ir},        {5'b0, e.irv});
            check("outputs",   e.idx, {mode, sel, shift_dr, capture_dr, update_dr, bp_shift, tdo_en, tdo}, e.f);
        end
    end

    // Drive one clock of stimulus and queue what must be visible after that edge
    task automatic step(input bit r, input bit t, input bit d, input bit b,
                        input logic [3:0] st, input logic [2:0] irv, input logic [7:0] f);
        @(negedge clk);
        #1;
        rst = r; tms = t; tdi = d; bsr_tdo = b;
        @(posedge clk);
        #1;
        q.push_back('{n_steps, st, irv, f});
        n_steps++;
    endtask

    // From RTI: load 'code' into IR; captured 001 always shifts out as 1,0,0
    task automatic ir_scan(input logic [2:0] code, input logic [2:0] ir_old,
                           input logic [7:0] f_old, input logic [7:0] f_new);
        step(0, 1, 0,       0, S_SDR, ir_old, f_old);
        step(0, 1, 0,       0, S_SIR, ir_old, f_old);
        step(0, 0, 0,       0, S_CIR, ir_old, f_old);
        step(0, 0, 0,       0, S_SHI, ir_old, f_old | F_EN | F_TDO);
        step(0, 0, code[0], 0, S_SHI, ir_old, f_old | F_EN);
        step(0, 0, code[1], 0, S_SHI, ir_old, f_old | F_EN);
        step(0, 1, code[2], 0, S_E1I, ir_old, f_old);
        step(0, 1, 0,       0, S_UIR, ir_old, f_old);
        step(0, 0, 0,       0, S_RTI, code,   f_new);
    endtask

    localparam logic [7:0] F_EXT = F_MOD | F_SEL;

    initial begin
        rst = 1'b1; tms = 1'b1; tdi = 1'b0; bsr_tdo = 1'b0;

        // Reset, including rst winning over tms=0
        step(1, 1, 0, 0, S_TLR, 3'b111, F_0);
        step(1, 0, 0, 0, S_TLR, 3'b111, F_0);

        // Bypass scan: tdi 1,0,1,1 appears one cycle late as 0,1,0,1
        step(0, 0, 0, 0, S_RTI, 3'b111, F_0);
        step(0, 1, 0, 0, S_SDR, 3'b111, F_0);
        step(0, 0, 0, 0, S_CDR, 3'b111, F_0);
        step(0, 0, 1, 1, S_SHD, 3'b111, F_BP | F_EN);
        step(0, 0, 1, 0, S_SHD, 3'b111, F_BP | F_EN | F_TDO);
        step(0, 0, 0, 1, S_SHD, 3'b111, F_BP | F_EN);
        step(0, 0, 1, 0, S_SHD, 3'b111, F_BP | F_EN | F_TDO);
        step(0, 1, 1, 0, S_E1D, 3'b111, F_0);
        // Pause and resume: bypass bit must still hold the last tdi
        step(0, 0, 0, 0, S_PAD, 3'b111, F_0);
        step(0, 0, 0, 0, S_PAD, 3'b111, F_0);
        step(0, 1, 0, 0, S_E2D, 3'b111, F_0);
        step(0, 0, 0, 0, S_SHD, 3'b111, F_BP | F_EN | F_TDO);
        step(0, 1, 0, 0, S_E1D, 3'b111, F_0);
        step(0, 1, 0, 0, S_UDR, 3'b111, F_0);
        step(0, 0, 0, 0, S_RTI, 3'b111, F_0);

        // Load EXTEST
        ir_scan(3'b000, 3'b111, F_0, F_EXT);

        // EXTEST DR scan: one capture, 8 shifts with tdo = bsr_tdo
        step(0, 1, 0, 0, S_SDR, 3'b000, F_EXT);
        step(0, 0, 0, 0, S_CDR, 3'b000, F_EXT | F_CAP);
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, i[0], S_SHD, 3'b000, F_EXT | F_SH | F_EN | (i[0] ? F_TDO : F_0));
        // Pause 3 clocks: no strobes, no tdo_en
        step(0, 1, 0, 1, S_E1D, 3'b000, F_EXT);
        step(0, 0, 0, 1, S_PAD, 3'b000, F_EXT);
        step(0, 0, 0, 1, S_PAD, 3'b000, F_EXT);
        step(0, 0, 0, 1, S_PAD, 3'b000, F_EXT);
        step(0, 1, 0, 1, S_E2D, 3'b000, F_EXT);
        step(0, 0, 0, 1, S_SHD, 3'b000, F_EXT | F_SH | F_EN | F_TDO);
        step(0, 1, 0, 0, S_E1D, 3'b000, F_EXT);
        step(0, 1, 0, 0, S_UDR, 3'b000, F_EXT | F_UPD);
        step(0, 0, 0, 0, S_RTI, 3'b000, F_EXT);

        // TMS reset from SH_IR; IR picks up 100 (a bypass code) on the way
        step(0, 1, 0, 0, S_SDR, 3'b000, F_EXT);
        step(0, 1, 0, 0, S_SIR, 3'b000, F_EXT);
        step(0, 0, 0, 0, S_CIR, 3'b000, F_EXT);
        step(0, 0, 0, 0, S_SHI, 3'b000, F_EXT | F_EN | F_TDO);
        step(0, 1, 1, 0, S_E1I, 3'b000, F_EXT);
        step(0, 1, 0, 0, S_UIR, 3'b000, F_EXT);
        step(0, 1, 0, 0, S_SDR, 3'b100, F_0);
        step(0, 1, 0, 0, S_SIR, 3'b100, F_0);
        step(0, 1, 0, 0, S_TLR, 3'b100, F_0);
        step(0, 1, 0, 0, S_TLR, 3'b111, F_0);

        // INTEST then SAMPLE decode
        step(0, 0, 0, 0, S_RTI, 3'b111, F_0);
        ir_scan(3'b001, 3'b111, F_0, F_EXT);
        ir_scan(3'b010, 3'b001, F_EXT, F_SEL);

        // SAMPLE DR scan, then reset in mid-shift
        step(0, 1, 0, 0, S_SDR, 3'b010, F_SEL);
        step(0, 0, 0, 0, S_CDR, 3'b010, F_SEL | F_CAP);
        step(0, 0, 0, 1, S_SHD, 3'b010, F_SEL | F_SH | F_EN | F_TDO);
        step(1, 0, 0, 1, S_TLR, 3'b111, F_0);
        step(0, 1, 0, 0, S_TLR, 3'b111, F_0);

        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
